rr_shared_reg_arbiter: RTL and testbench

Round-robin arbiter that shares one registered capture stage (a single DATA_W flop bank with valid) among NUM_REQ requesters. It sits between several independent requesting submodules and the shared register, so that only one requester drives it per transaction. A configurable hold interval keeps the resource busy after each capture. Intended as a synthesis/simulation regression block exercising FSMs, counters and one-hot grant logic.

---
 rtl/rr_shared_reg_arbiter_if.sv | 31 +++
 rtl/rr_shared_reg_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_rr_shared_reg_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/rr_shared_reg_arbiter_if.sv
// rtl/rr_shared_reg_arbiter_if.sv - requester/arbiter bus bundle for rr_shared_reg_arbiter
// Carries the lock vector only when RR_ARB_LOCK_EN is defined.
interface rr_shared_reg_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8
);
   localparam int ID_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*DATA_W-1:0] data_in;
`ifdef RR_ARB_LOCK_EN
   logic [NUM_REQ-1:0]        lock;
`endif
   logic [NUM_REQ-1:0]        grant;
   logic                      out_valid;
   logic [DATA_W-1:0]         out_data;
   logic [ID_W-1:0]           out_id;
   logic                      busy;

`ifdef RR_ARB_LOCK_EN
   modport master (output req, data_in, lock,
                   input  grant, out_valid, out_data, out_id, busy);
   modport slave  (input  req, data_in, lock,
                   output grant, out_valid, out_data, out_id, busy);
`else
   modport master (output req, data_in,
                   input  grant, out_valid, out_data, out_id, busy);
   modport slave  (input  req, data_in,
                   output grant, out_valid, out_data, out_id, busy);
`endif
endinterface

// File: rtl/rr_shared_reg_arbiter.sv
// rtl/rr_shared_reg_arbiter.sv - round-robin arbiter sharing one capture register among NUM_REQ requesters
// Optional ownership lock is enabled by defining RR_ARB_LOCK_EN.
module rr_shared_reg_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = 8,
   parameter int HOLD_CYCLES = 1,
   parameter int MAX_LOCK    = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   rr_shared_reg_arbiter_if.slave bus
);
   localparam int              ID_W      = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
   localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);
   localparam logic [3:0]      HOLD_LOAD = (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : 4'd0;

   if (NUM_REQ < 2 || NUM_REQ > 16 || HOLD_CYCLES < 0 || HOLD_CYCLES > 15 || MAX_LOCK < 1) begin : g_param_check
      $error("rr_shared_reg_arbiter: parameter out of range");
   end

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_HOLD} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ID_W-1:0]     r_ptr;
   logic [ID_W-1:0]     w_ptr_nxt;
   logic [ID_W-1:0]     r_win;
   logic [ID_W-1:0]     w_win_nxt;
   logic [NUM_REQ-1:0]  r_grant;
   logic [NUM_REQ-1:0]  w_grant_nxt;
   logic [3:0]          r_cnt;
   logic [3:0]          w_cnt_nxt;
   logic                r_out_valid;
   logic [DATA_W-1:0]   r_out_data;
   logic [ID_W-1:0]     r_out_id;

   logic                w_busy;
   logic                w_capture;
   logic                w_issue;
   logic                w_issue_locked;
   logic                w_lock_now;
   logic                w_lock_resume;
   logic [ID_W-1:0]     w_ptr_inc;
   logic [NUM_REQ-1:0]  w_req_excl;
   logic                w_any_req;
   logic                w_any_excl;
   logic [ID_W-1:0]     w_pick_ptr;
   logic [ID_W-1:0]     w_pick_excl;

   // First set bit at or above p, wrapping past NUM_REQ-1 back to 0.
   function automatic logic [ID_W-1:0] pick(input logic [NUM_REQ-1:0] r, input logic [ID_W-1:0] p);
      logic [ID_W-1:0] sel;
      logic [ID_W-1:0] idx_t;
      logic            found;
      int              idx;
      sel   = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(p) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         idx_t = idx[ID_W-1:0];
         if (!found && r[idx_t]) begin
            found = 1'b1;
            sel   = idx_t;
         end
      end
      return sel;
   endfunction

   // The current owner's req is ignored when picking a back-to-back successor.
   assign w_ptr_inc   = (r_win == LAST_ID) ? '0 : r_win + 1'b1;
   assign w_req_excl  = bus.req & ~r_grant;
   assign w_any_req   = |bus.req;
   assign w_any_excl  = |w_req_excl;
   assign w_pick_ptr  = pick(bus.req, r_ptr);
   assign w_pick_excl = pick(w_req_excl, w_ptr_inc);

`ifdef RR_ARB_LOCK_EN
   localparam int LC_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK + 1) : 1;

   logic [LC_W-1:0] r_lock_cnt;
   logic            r_lock_pend;

   assign w_lock_now    = (r_state == S_GRANT) && bus.lock[r_win] && bus.req[r_win]
                          && (int'(r_lock_cnt) < MAX_LOCK - 1);
   assign w_lock_resume = r_lock_pend && bus.req[r_win];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_lock_cnt  <= '0;
         r_lock_pend <= 1'b0;
      end else begin
         if (w_issue)
            r_lock_pend <= 1'b0;
         else if (r_state == S_GRANT)
            r_lock_pend <= w_lock_now;
         else if (w_state_nxt == S_IDLE)
            r_lock_pend <= 1'b0;
         if (w_issue)
            r_lock_cnt <= w_issue_locked ? r_lock_cnt + 1'b1 : '0;
      end
   end
`else
   assign w_lock_now    = 1'b0;
   assign w_lock_resume = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_win   <= '0;
         r_grant <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_win   <= w_win_nxt;
         r_grant <= w_grant_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_ptr_nxt      = r_ptr;
      w_win_nxt      = r_win;
      w_cnt_nxt      = r_cnt;
      w_grant_nxt    = '0;
      w_issue        = 1'b0;
      w_issue_locked = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any_req) begin
               w_issue   = 1'b1;
               w_win_nxt = w_pick_ptr;
            end
         end
         S_GRANT: begin
            w_ptr_nxt = w_ptr_inc;
            if (HOLD_CYCLES > 0) begin
               w_state_nxt = S_HOLD;
               w_cnt_nxt   = HOLD_LOAD;
            end else if (w_lock_now) begin
               w_issue        = 1'b1;
               w_issue_locked = 1'b1;
            end else if (w_any_excl) begin
               w_issue   = 1'b1;
               w_win_nxt = w_pick_excl;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_HOLD: begin
            if (r_cnt != 4'd0) begin
               w_cnt_nxt = r_cnt - 4'd1;
            end else if (w_lock_resume) begin
               w_issue        = 1'b1;
               w_issue_locked = 1'b1;
            end else if (w_any_req) begin
               w_issue   = 1'b1;
               w_win_nxt = w_pick_ptr;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_issue) begin
         w_state_nxt = S_GRANT;
         w_grant_nxt = NUM_REQ'(1) << w_win_nxt;
      end
   end

   always_comb begin
      w_busy    = (r_state != S_IDLE);
      w_capture = (r_state == S_GRANT);
   end

   // Reset wins over an in-flight GRANT, so a discarded capture never pulses out_valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_id    <= '0;
      end else begin
         r_out_valid <= w_capture;
         if (w_capture) begin
            r_out_data <= bus.data_in[int'(r_win)*DATA_W +: DATA_W];
            r_out_id   <= r_win;
         end
      end
   end

   assign bus.grant     = r_grant;
   assign bus.busy      = w_busy;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_id    = r_out_id;

endmodule

// File: tb/tb_rr_shared_reg_arbiter.sv
// tb/tb_rr_shared_reg_arbiter.sv - self-checking bench for rr_shared_reg_arbiter
// Directed literal scenarios followed by randomized traffic, all checked against a behavioural model.
module tb_rr_shared_reg_arbiter;
   localparam int N    = 4;
   localparam int DW   = 8;
   localparam int HOLD = 1;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   rr_shared_reg_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

   rr_shared_reg_arbiter #(
      .NUM_REQ(N), .DATA_W(DW), .HOLD_CYCLES(HOLD), .MAX_LOCK(4)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

`ifdef RR_ARB_LOCK_EN
   initial bus.lock = '0;
`endif

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: owner of the pending/current grant (-1 none), remaining hold cycles, pointer.
   int         m_gnt  = -1;
   int         m_cool = 0;
   int         m_ptr  = 0;
   logic       m_ov   = 1'b0;
   logic [7:0] m_od   = 8'h00;
   int         m_oid  = 0;

   function automatic int pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   always @(posedge clk) begin : model
      int w;
      if (reset) begin
         m_gnt = -1; m_cool = 0; m_ptr = 0;
         m_ov = 1'b0; m_od = 8'h00; m_oid = 0;
      end else begin
         m_ov = 1'b0;
         if (m_gnt >= 0) begin
            w     = m_gnt;
            m_ov  = 1'b1;
            m_od  = bus.data_in[w*DW +: DW];
            m_oid = w;
            m_ptr = (w + 1) % N;
            if (HOLD > 0) begin
               m_cool = HOLD;
               m_gnt  = -1;
            end else begin
               m_gnt = pick(bus.req & ~(N'(1) << w), m_ptr);
            end
         end else if (m_cool > 0) begin
            m_cool = m_cool - 1;
            m_gnt  = (m_cool == 0) ? pick(bus.req, m_ptr) : -1;
         end else begin
            m_gnt = pick(bus.req, m_ptr);
         end
      end
   end

   always @(negedge clk) begin : compare
      logic [N-1:0] eg;
      eg = (m_gnt >= 0) ? (N'(1) << m_gnt) : '0;
      check("model_grant",     bus.grant,     eg);
      check("model_busy",      bus.busy,      (m_gnt >= 0 || m_cool > 0));
      check("model_out_valid", bus.out_valid, m_ov);
      check("model_out_data",  bus.out_data,  m_od);
      check("model_out_id",    bus.out_id,    m_oid);
   end

   initial begin : stim
      int           ids[$];
      int           cyc[$];
      int           order[$];
      logic [N-1:0] r;

      reset       = 1'b1;
      bus.req     = 4'b1111;
      bus.data_in = 32'hDEADBEEF;
      repeat (3) begin
         @(negedge clk);
         check("rst_grant", bus.grant, 0);
         check("rst_out_valid", bus.out_valid, 0);
         check("rst_out_data", bus.out_data, 8'h00);
         check("rst_busy", bus.busy, 0);
      end
      reset   = 1'b0;
      bus.req = '0;
      repeat (2) @(negedge clk);

      bus.req     = 4'b0100;
      bus.data_in = 32'h00A5_0000;
      @(negedge clk);
      check("single_grant", bus.grant, 4'b0100);
      bus.req = '0;
      @(negedge clk);
      check("single_valid", bus.out_valid, 1);
      check("single_data", bus.out_data, 8'hA5);
      check("single_id", bus.out_id, 2);
      repeat (3) @(negedge clk);

      reset = 1'b1;
      @(negedge clk);
      reset       = 1'b0;
      bus.req     = 4'b1111;
      bus.data_in = 32'h1312_1110;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            ids.push_back(int'(bus.out_id));
            cyc.push_back(c);
            check("rot_data", bus.out_data, 8'h10 + 8'(bus.out_id));
         end
      end
      check("rot_count_ge5", (ids.size() >= 5), 1);
      for (int i = 0; i < 5 && i < ids.size(); i++) begin
         check("rot_id", ids[i], i % N);
         if (i > 0) check("rot_spacing", cyc[i] - cyc[i-1], 2);
      end
      bus.req = '0;
      repeat (4) @(negedge clk);

      reset = 1'b1;
      @(negedge clk);
      reset   = 1'b0;
      bus.req = 4'b0001;
      @(negedge clk);
      check("wrap_setup_grant", bus.grant, 4'b0001);
      bus.req = '0;
      repeat (3) @(negedge clk);
      bus.req = 4'b1001;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (bus.grant[i]) order.push_back(i);
         end
         bus.req = bus.req & ~bus.grant;
      end
      check("wrap_count", order.size(), 2);
      if (order.size() >= 2) begin
         check("wrap_first", order[0], 3);
         check("wrap_second", order[1], 0);
      end
      bus.req = 4'b1111;
      @(negedge clk);
      check("wrap_ptr_end", bus.grant, 4'b0010);
      bus.req = '0;
      repeat (3) @(negedge clk);

      bus.req     = 4'b0010;
      bus.data_in = 32'h0000_5A00;
      @(negedge clk);
      check("mh_grant", bus.grant, 4'b0010);
      bus.req = '0;
      @(negedge clk);
      check("mh_in_hold", bus.busy, 1);
      reset = 1'b1;
      @(negedge clk);
      check("mh_busy", bus.busy, 0);
      check("mh_grant0", bus.grant, 0);
      check("mh_valid0", bus.out_valid, 0);
      reset   = 1'b0;
      bus.req = 4'b1111;
      @(negedge clk);
      check("mh_ptr_zero", bus.grant, 4'b0001);
      bus.req = '0;
      repeat (3) @(negedge clk);
      bus.req = 4'b0010;
      @(negedge clk);
      check("mh_regrant", bus.grant, 4'b0010);
      bus.req = '0;
      reset   = 1'b1;
      @(negedge clk);
      check("mg_no_pulse", bus.out_valid, 0);
      check("mg_data_clear", bus.out_data, 8'h00);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      r = '0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 299) == 0);
         for (int i = 0; i < N; i++) begin
            if (bus.grant[i])
               r[i] = ($urandom_range(0, 7) == 0);
            else if (r[i])
               r[i] = ($urandom_range(0, 39) != 0);
            else
               r[i] = ($urandom_range(0, 3) == 0);
         end
         bus.req     = r;
         bus.data_in = $urandom();
      end
      reset   = 1'b0;
      bus.req = '0;
      repeat (4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
